// File: rtl/sigmoid_pkg.sv
// sigmoid_pkg
//   Shared definitions for the piecewise-linear sigmoid pipeline:
//   mode encoding, segment codes, breakpoint and offset helpers and the
//   sign-extended absolute value helper.
//   Breakpoints are returned scaled by 2^(IN_FRAC+3). The extra factor of 8
//   keeps 2.375 exact even when IN_FRAC < 3. The magnitude being compared
//   is shifted left by 3 to match.
package sigmoid_pkg;

    typedef enum logic {
        MODE_HARD = 1'b0,
        MODE_PLAN = 1'b1
    } mode_e;

    // Segment code computed in S1 and used by the evaluator in S2.
    typedef enum logic [1:0] {
        SEG_LIN  = 2'd0,   // a < 1.0
        SEG_MID  = 2'd1,   // 1.0   <= a < 2.375
        SEG_TAIL = 2'd2,   // 2.375 <= a < 5.0
        SEG_SAT  = 2'd3    // a >= 5.0
    } seg_e;

    // Transistors per bit of a regp_en bank: FD2 flop plus hold mux.
    localparam int unsigned REGP_BIT_TRANS = 36;

    // Breakpoints, scaled by 2^(in_frac+3).
    function automatic logic [31:0] t1_x8(input int in_frac);
        return 32'd8 << in_frac;              // 1.0
    endfunction

    function automatic logic [31:0] t2_x8(input int in_frac);
        return 32'd19 << in_frac;             // 2.375 = 19/8
    endfunction

    function automatic logic [31:0] t3_x8(input int in_frac);
        return 32'd40 << in_frac;             // 5.0
    endfunction

    function automatic logic [31:0] thard_x8(input int in_frac);
        return 32'd16 << in_frac;             // 2.0
    endfunction

    // Offsets in Q.f, where f = OUT_W-1 fraction bits.
    function automatic logic [31:0] off_half(input int f);
        return 32'd1 << (f - 1);              // 0.5
    endfunction

    function automatic logic [31:0] off_5_8(input int f);
        return 32'd5 << (f - 3);              // 0.625
    endfunction

    function automatic logic [31:0] off_27_32(input int f);
        return 32'd27 << (f - 5);             // 0.84375
    endfunction

    // |v| for a sign-extended 32-bit value. The most negative input of any
    // legal IN_W comes out exact.
    function automatic logic [31:0] abs_ext(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/sigmoid_pwl_pipe_regp_en.sv
// regp_en
//   BW-bit FD2 register bank with hold enable and synchronous active-low
//   reset. Each pipeline stage of sigmoid_pwl_pipe uses one of these.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : synchronous active-low reset, clears q
//     en     : 1 = load d, 0 = hold
//     d, q   : data in/out, BW bits
//     number : transistor count of this bank (constant)
module regp_en
    import sigmoid_pkg::*;
#(
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [BW-1:0] d,
    output logic [BW-1:0] q,
    output logic [50:0]   number
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

    assign number = 51'(BW) * 51'(REGP_BIT_TRANS);

endmodule

// File: rtl/sigmoid_pwl_pipe.sv
// sigmoid_pwl_pipe
//   Three-stage pipelined sigmoid approximator with two modes:
//     HARD : y = 0.5 + x/4, clamped to [0,1]
//     PLAN : 4-segment shift-add curve, mirrored for negative x
//   Ports:
//     clk, rst_n     : clock, synchronous active-low reset
//     i_in_valid     : input sample valid
//     o_in_ready     : sample accepted this cycle when high with i_in_valid
//     i_x            : signed input, IN_FRAC fraction bits
//     i_mode         : 0 = HARD, 1 = PLAN, travels with i_x
//     o_y            : result, unsigned Q1.(OUT_W-1)
//     o_out_valid    : o_y valid
//     i_out_ready    : downstream accepts o_y
//     number         : transistor count of all register banks (constant)
module sigmoid_pwl_pipe
    import sigmoid_pkg::*;
#(
    parameter int IN_W    = 8,
    parameter int IN_FRAC = 5,
    parameter int OUT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [IN_W-1:0]  i_x,
    input  logic             i_mode,
    output logic [OUT_W-1:0] o_y,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [50:0]      number
);

    localparam int F  = OUT_W - 1;          // output fraction bits
    localparam int AW = OUT_W + 2;          // internal arithmetic width

    // Stage register widths:
    //   S1: v, mode, neg, hsat, seg[1:0], x, a
    //   S2: v, mode, neg, base
    //   S3: v, y
    localparam int W1 = 2 * IN_W + 7;
    localparam int W2 = OUT_W + 3;
    localparam int W3 = OUT_W + 1;

    // Breakpoints in the x8 scaled domain. A breakpoint above the largest
    // positive input code can never be reached. This also rules out the
    // lone magnitude 2^(IN_W-1), which only the most negative input has.
    localparam logic [31:0] MAXPOS_X8 = ((32'd1 << (IN_W - 1)) - 32'd1) << 3;
    localparam logic [31:0] T1_X8     = t1_x8(IN_FRAC);
    localparam logic [31:0] T2_X8     = t2_x8(IN_FRAC);
    localparam logic [31:0] T3_X8     = t3_x8(IN_FRAC);
    localparam logic [31:0] TH_X8     = thard_x8(IN_FRAC);
    localparam logic        REACH_T1  = (T1_X8 <= MAXPOS_X8);
    localparam logic        REACH_T2  = (T2_X8 <= MAXPOS_X8);
    localparam logic        REACH_T3  = (T3_X8 <= MAXPOS_X8);
    localparam logic        REACH_TH  = (TH_X8 <= MAXPOS_X8);

    localparam logic [AW-1:0] ONE  = AW'(1) << F;
    localparam logic [AW-1:0] OFF0 = AW'(off_half(F));
    localparam logic [AW-1:0] OFF1 = AW'(off_5_8(F));
    localparam logic [AW-1:0] OFF2 = AW'(off_27_32(F));

    // Slopes 1/4, 1/8 and 1/32 as left shifts from IN_FRAC to F fraction bits.
    localparam int SH0 = F - IN_FRAC - 2;
    localparam int SH1 = F - IN_FRAC - 3;
    localparam int SH2 = F - IN_FRAC - 5;

    // ------------------------------------------------------------------
    // Handshake. A sample moves on a clock edge when valid & ready. When
    // the output holds valid data and downstream is not ready, the whole
    // pipeline stalls: every stage holds and o_in_ready drops. Otherwise
    // all stages advance together. Empty (v=0) stages advance as bubbles.
    // ------------------------------------------------------------------
    logic stall;
    logic en;
    logic accept;

    assign stall      = o_out_valid & ~i_out_ready;
    assign en         = ~stall;
    assign o_in_ready = ~stall & rst_n;
    assign accept     = i_in_valid & o_in_ready;

    // ------------------------------------------------------------------
    // S1: magnitude, sign and segment classification
    // ------------------------------------------------------------------
    logic [31:0] x_sext;
    logic [31:0] a_full;
    logic [31:0] a_x8;
    seg_e        seg_d;
    logic        hsat_d;
    logic [W1-1:0] s1_d;
    logic [W1-1:0] s1_q;

    assign x_sext = 32'($signed(i_x));
    assign a_full = abs_ext(x_sext);
    assign a_x8   = a_full << 3;

    always_comb begin
        seg_d = SEG_LIN;
        if (REACH_T3 && (a_x8 >= T3_X8)) begin
            seg_d = SEG_SAT;
        end else if (REACH_T2 && (a_x8 >= T2_X8)) begin
            seg_d = SEG_TAIL;
        end else if (REACH_T1 && (a_x8 >= T1_X8)) begin
            seg_d = SEG_MID;
        end
    end

    // HARD saturates for |x| >= 2. The saturated case is handled by this
    // flag, so the linear HARD term only sees |x| < 2 and always fits AW bits.
    assign hsat_d = REACH_TH && (a_x8 >= TH_X8);

    assign s1_d = {accept, i_mode, i_x[IN_W-1], hsat_d, seg_d, i_x,
                   (IN_W + 1)'(a_full)};

    logic [50:0] num1;
    regp_en #(.BW(W1)) u_s1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .d      (s1_d),
        .q      (s1_q),
        .number (num1)
    );

    logic            s1_v;
    logic            s1_mode;
    logic            s1_neg;
    logic            s1_hsat;
    logic [1:0]      s1_seg;
    logic [IN_W-1:0] s1_x;
    logic [IN_W:0]   s1_a;

    assign {s1_v, s1_mode, s1_neg, s1_hsat, s1_seg, s1_x, s1_a} = s1_q;

    // ------------------------------------------------------------------
    // S2: base value (segment evaluator)
    // ------------------------------------------------------------------
    logic signed [AW-1:0] x_w;
    logic signed [AW-1:0] h;
    logic [AW-1:0]        a_w;
    logic [AW-1:0]        plan_b;
    logic [AW-1:0]        hard_b;
    logic [AW-1:0]        base_d;
    logic [W2-1:0]        s2_d;
    logic [W2-1:0]        s2_q;

    assign x_w = AW'($signed(s1_x));
    assign a_w = AW'(s1_a);
    assign h   = $signed(OFF0) + (x_w <<< SH0);

    always_comb begin
        plan_b = OFF0 + (a_w << SH0);
        case (s1_seg)
            SEG_SAT:  plan_b = ONE;
            SEG_TAIL: plan_b = OFF2 + (a_w << SH2);
            SEG_MID:  plan_b = OFF1 + (a_w << SH1);
            default:  plan_b = OFF0 + (a_w << SH0);
        endcase
    end

    always_comb begin
        hard_b = h;
        if (s1_hsat) begin
            hard_b = s1_neg ? '0 : ONE;
        end else if (h[AW-1]) begin
            hard_b = '0;
        end else if (h > $signed(ONE)) begin
            hard_b = ONE;
        end
    end

    assign base_d = (s1_mode == MODE_PLAN) ? plan_b : hard_b;
    assign s2_d   = {s1_v, s1_mode, s1_neg, OUT_W'(base_d)};

    logic [50:0] num2;
    regp_en #(.BW(W2)) u_s2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .d      (s2_d),
        .q      (s2_q),
        .number (num2)
    );

    logic             s2_v;
    logic             s2_mode;
    logic             s2_neg;
    logic [OUT_W-1:0] s2_base;

    assign {s2_v, s2_mode, s2_neg, s2_base} = s2_q;

    // ------------------------------------------------------------------
    // S3: mirror negative PLAN inputs around 0.5, then drive the outputs
    // ------------------------------------------------------------------
    logic [AW-1:0] y_w;
    logic [W3-1:0] s3_d;
    logic [W3-1:0] s3_q;

    assign y_w  = ((s2_mode == MODE_PLAN) && s2_neg) ? (ONE - AW'(s2_base))
                                                     : AW'(s2_base);
    assign s3_d = {s2_v, OUT_W'(y_w)};

    logic [50:0] num3;
    regp_en #(.BW(W3)) u_s3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .d      (s3_d),
        .q      (s3_q),
        .number (num3)
    );

    assign {o_out_valid, o_y} = s3_q;

    assign number = num1 + num2 + num3;

endmodule

// File: tb/tb_sigmoid_pwl_pipe.sv
// tb_sigmoid_pwl_pipe
//   Directed bench for sigmoid_pwl_pipe with default parameters.
//   Expected outputs are hand-computed (F = 15, 1.0 = 0x8000).
module tb_sigmoid_pwl_pipe;

    localparam int IN_W    = 8;
    localparam int IN_FRAC = 5;
    localparam int OUT_W   = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             i_in_valid;
    logic             o_in_ready;
    logic [IN_W-1:0]  i_x;
    logic             i_mode;
    logic [OUT_W-1:0] o_y;
    logic             o_out_valid;
    logic             i_out_ready;
    logic [50:0]      number;

    sigmoid_pwl_pipe #(
        .IN_W    (IN_W),
        .IN_FRAC (IN_FRAC),
        .OUT_W   (OUT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_x         (i_x),
        .i_mode      (i_mode),
        .o_y         (o_y),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .number      (number)
    );

    // ---------------- check / counters ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    // ---------------- scoreboard ----------------
    logic [OUT_W-1:0] exp_in;          // hand-computed result travelling with the sample
    logic [OUT_W-1:0] exp_q[$];
    int               acc_q[$];
    int               cyc = 0;
    bit               lat_chk_en = 1'b0;

    // Record accepted samples; a reset edge drops everything in flight.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
        end else if (i_in_valid && o_in_ready) begin
            exp_q.push_back(exp_in);
            acc_q.push_back(cyc);
        end
        cyc = cyc + 1;
    end

    // Output transfers are checked in order against the expected queue.
    always @(negedge clk) begin
        if (rst_n && o_out_valid && i_out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_output", 32'(o_out_valid), 32'd0);
            end else begin
                logic [OUT_W-1:0] e;
                int               a;
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                check("y", 32'(o_y), 32'(e));
                if (lat_chk_en) check("latency", cyc - a, 32'd3);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [IN_W-1:0] x, input logic m, input logic [OUT_W-1:0] e);
        i_in_valid = 1'b1;
        i_x        = x;
        i_mode     = m;
        exp_in     = e;
        tick();
        i_in_valid = 1'b0;
    endtask

    // ---------------- vectors ----------------
    // HARD: 0x4000 + x*256, clamped; |x| >= 2.0 saturates.
    logic [IN_W-1:0]  hard_x[5] = '{8'h3F, 8'hC0, 8'h40, 8'h80, 8'h00};
    logic [OUT_W-1:0] hard_e[5] = '{16'h7F00, 16'h0000, 16'h8000, 16'h0000, 16'h4000};

    // PLAN: 1.0, -1.0, 0.5, 3.0, -4.0, 2.34375 (just below 2.375),
    // 2.375 (breakpoint), 3.96875 (largest positive input).
    logic [IN_W-1:0]  plan_x[8] = '{8'h20, 8'hE0, 8'h10, 8'h60, 8'h80, 8'h4B, 8'h4C, 8'h7F};
    logic [OUT_W-1:0] plan_e[8] = '{16'h6000, 16'h2000, 16'h5000, 16'h7800,
                                    16'h0400, 16'h7580, 16'h7580, 16'h7BE0};

    // Stream of 10 PLAN samples covering all three reachable segments and both signs.
    logic [IN_W-1:0]  strm_x[10] = '{8'h00, 8'h08, 8'h10, 8'h18, 8'h20,
                                     8'h28, 8'hF8, 8'hD8, 8'h50, 8'hA0};
    logic [OUT_W-1:0] strm_e[10] = '{16'h4000, 16'h4800, 16'h5000, 16'h5800, 16'h6000,
                                     16'h6400, 16'h3800, 16'h1C00, 16'h7600, 16'h0800};

    // ---------------- main sequence ----------------
    initial begin
        logic [5:0]       pat;
        logic [OUT_W-1:0] held_y;
        bit               held;
        int               idx;

        rst_n       = 1'b0;
        i_in_valid  = 1'b0;
        i_x         = '0;
        i_mode      = 1'b0;
        i_out_ready = 1'b1;
        exp_in      = '0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("rst_out_valid", 32'(o_out_valid), 32'd0);
        check("rst_y",         32'(o_y),         32'd0);
        check("rst_in_ready",  32'(o_in_ready),  32'd0);
        // Stage banks hold 23 + 19 + 17 = 59 bits at 36 transistors per bit.
        check("number", 32'(number), 32'd2124);
        tick();
        rst_n = 1'b1;
        #1;
        check("release_in_ready", 32'(o_in_ready), 32'd1);

        lat_chk_en = 1'b1;

        // HARD sweep, back to back
        for (int i = 0; i < 5; i++) send(hard_x[i], 1'b0, hard_e[i]);
        idle(5);

        // PLAN points, back to back
        for (int i = 0; i < 8; i++) send(plan_x[i], 1'b1, plan_e[i]);
        idle(5);

        // Mode mix: x = 1.0 gives 0x6000 in both modes. For x = 1.5,
        // HARD gives 0.875 = 0x7000 and PLAN gives 1.5/8 + 0.625 = 0x6800.
        send(8'h20, 1'b0, 16'h6000);
        send(8'h20, 1'b1, 16'h6000);
        send(8'h30, 1'b0, 16'h7000);
        send(8'h30, 1'b1, 16'h6800);
        idle(5);

        // Bubbles: o_out_valid replays the input valid pattern 3 cycles later
        pat = 6'b100101;                 // cycle order 1,0,1,0,0,1
        for (int k = 0; k < 9; k++) begin
            i_in_valid = (k < 6) ? pat[k] : 1'b0;
            i_x        = 8'h00;
            i_mode     = 1'b0;
            exp_in     = 16'h4000;
            @(negedge clk);
            if (k >= 3) check("bubble_valid", 32'(o_out_valid), 32'(pat[k-3]));
            tick();
        end
        idle(4);

        // Stream with 4 cycles of backpressure mid-stream
        lat_chk_en = 1'b0;
        idx  = 0;
        held = 1'b0;
        held_y = '0;
        for (int c = 0; c < 40 && idx < 10; c++) begin
            i_out_ready = !(c >= 6 && c < 10);
            i_in_valid  = 1'b1;
            i_x         = strm_x[idx];
            i_mode      = 1'b1;
            exp_in      = strm_e[idx];
            #1;
            if (o_out_valid && !i_out_ready) begin
                check("stall_in_ready", 32'(o_in_ready), 32'd0);
                if (held) check("stall_hold_y", 32'(o_y), 32'(held_y));
                else begin
                    held_y = o_y;
                    held   = 1'b1;
                end
            end
            if (o_in_ready) idx++;
            tick();
        end
        i_in_valid  = 1'b0;
        i_out_ready = 1'b1;
        check("stream_sent", idx, 32'd10);
        check("stall_seen", 32'(held), 32'd1);
        idle(8);
        lat_chk_en = 1'b1;

        // Reset with 3 samples in flight; none of them may ever appear
        send(8'h20, 1'b1, 16'h6000);
        send(8'h10, 1'b1, 16'h5000);
        send(8'hD8, 1'b1, 16'h1C00);
        rst_n       = 1'b0;
        i_out_ready = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(o_in_ready), 32'd0);
        tick();
        rst_n       = 1'b1;
        i_out_ready = 1'b1;
        #1;
        check("midrst_out_valid", 32'(o_out_valid), 32'd0);
        check("midrst_in_ready_release", 32'(o_in_ready), 32'd1);
        idle(6);

        // One more sample after the flush to show the pipe still works
        send(8'h60, 1'b1, 16'h7800);
        idle(6);

        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
